// File: rtl/nmi_wdog_seq.sv
// rtl/nmi_wdog_seq.sv - 3 kHz prescaler, periodic NMI J/K sequencer and CPU watchdog
// NMI set/clear are produced as J/K/enable strobes for an external flip-flop; watchdog holds wdog_rst for WDOG_LEN clk_en cycles.
module nmi_wdog_seq #(
    parameter int DIV        = 4000,
    parameter int NMI_TICKS  = 12,
    parameter int WDOG_TICKS = 256,
    parameter int WDOG_LEN   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic wdog_clr,
    input  logic nmi_ack,
    output logic tick_3k,
    output logic nmi_j,
    output logic nmi_k,
    output logic nmi_en,
    output logic wdog_rst
);

    localparam logic [15:0] PRE_LAST = 16'(DIV - 1);
    localparam logic [7:0]  NMI_LAST = 8'(NMI_TICKS - 1);
    localparam logic [9:0]  WD_LAST  = 10'(WDOG_TICKS - 1);
    localparam logic [7:0]  LEN_LAST = 8'(WDOG_LEN - 1);

    typedef enum logic {
        RUN  = 1'b0,
        FIRE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [7:0]  nmi_cnt_q, nmi_cnt_d;
    logic [9:0]  wd_q, wd_d;
    logic [7:0]  len_q, len_d;
    logic        pend_q, pend_d;
    logic        j_q, j_d;
    logic        k_q, k_d;
    logic        en_q, en_d;
    logic        wrst_q, wrst_d;
    logic        tick;
    logic        set_ev;
    logic        clr_ev;
    logic        fire;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        nmi_cnt_d = nmi_cnt_q;
        wd_d      = wd_q;
        len_d     = len_q;
        pend_d    = pend_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        tick      = 1'b0;
        set_ev    = 1'b0;
        clr_ev    = 1'b0;
        fire      = 1'b0;

        case (state_q)
            RUN: begin
                tick = clk_en && (pre_q == PRE_LAST);
                if (clk_en) begin
                    pre_d = tick ? 16'd0 : pre_q + 16'd1;
                end

                // a clear strobe landing on the tick cycle beats the advance
                fire = tick && !wdog_clr && (wd_q == WD_LAST);
                if (wdog_clr) begin
                    wd_d = 10'd0;
                end else if (tick) begin
                    wd_d = wd_q + 10'd1;
                end

                set_ev = tick && (nmi_cnt_q == NMI_LAST);
                if (tick) begin
                    nmi_cnt_d = set_ev ? 8'd0 : nmi_cnt_q + 8'd1;
                end

                // an ack arriving in a clk_en cycle is consumed immediately
                clr_ev = clk_en && (pend_q || nmi_ack);
                pend_d = (pend_q || nmi_ack) && !clk_en;

                if (fire) begin
                    state_d   = FIRE;
                    pre_d     = 16'd0;
                    nmi_cnt_d = 8'd0;
                    wd_d      = 10'd0;
                    len_d     = 8'd0;
                    pend_d    = 1'b0;
                end else begin
                    j_d = set_ev;
                    k_d = clr_ev && !set_ev;
                end
            end

            FIRE: begin
                pre_d     = 16'd0;
                nmi_cnt_d = 8'd0;
                wd_d      = 10'd0;
                pend_d    = 1'b0;
                if (clk_en) begin
                    if (len_q == LEN_LAST) begin
                        state_d = RUN;
                        len_d   = 8'd0;
                    end else begin
                        len_d = len_q + 8'd1;
                    end
                end
            end

            default: state_d = RUN;
        endcase

        en_d   = j_d || k_d;
        wrst_d = (state_d == FIRE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            pre_q     <= 16'd0;
            nmi_cnt_q <= 8'd0;
            wd_q      <= 10'd0;
            len_q     <= 8'd0;
            pend_q    <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            en_q      <= 1'b0;
            wrst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            nmi_cnt_q <= nmi_cnt_d;
            wd_q      <= wd_d;
            len_q     <= len_d;
            pend_q    <= pend_d;
            j_q       <= j_d;
            k_q       <= k_d;
            en_q      <= en_d;
            wrst_q    <= wrst_d;
        end
    end

    // tick is combinational from clk_en, so it is masked while reset is applied
    assign tick_3k  = rst && tick;
    assign nmi_j    = j_q;
    assign nmi_k    = k_q;
    assign nmi_en   = en_q;
    assign wdog_rst = wrst_q;

endmodule

// File: tb/tb_nmi_wdog_seq.sv
// tb/tb_nmi_wdog_seq.sv - directed bench for nmi_wdog_seq with DIV=4, NMI_TICKS=3, WDOG_TICKS=5, WDOG_LEN=6
module tb_nmi_wdog_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    logic wdog_clr = 1'b0;
    logic nmi_ack = 1'b0;
    logic tick_3k, nmi_j, nmi_k, nmi_en, wdog_rst;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    string phase = "reset";

    nmi_wdog_seq #(
        .DIV(4), .NMI_TICKS(3), .WDOG_TICKS(5), .WDOG_LEN(6)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wdog_clr(wdog_clr), .nmi_ack(nmi_ack),
        .tick_3k(tick_3k), .nmi_j(nmi_j), .nmi_k(nmi_k), .nmi_en(nmi_en), .wdog_rst(wdog_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s cyc=%0d got=%0b exp=%0b", phase, tag, cyc, got, exp);
        end
    endtask

    // inputs are applied for the current cycle, outputs sampled mid-cycle, then one clock passes
    task automatic run_cycle(input logic en, input logic clr, input logic ack,
                             input logic e_tick, input logic e_j, input logic e_k, input logic e_wrst);
        clk_en   = en;
        wdog_clr = clr;
        nmi_ack  = ack;
        #1;
        chk("tick", tick_3k, e_tick);
        chk("j", nmi_j, e_j);
        chk("k", nmi_k, e_k);
        chk("en", nmi_en, e_j | e_k);
        chk("wrst", wdog_rst, e_wrst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clk_en = 1'b1;
        nmi_ack = 1'b1;
        wdog_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        nmi_ack = 1'b0;
    endtask

    initial begin
        // reset state with clk_en high and a stray ack
        rst = 1'b0;
        clk_en = 1'b1;
        nmi_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", tick_3k, 1'b0);
        chk("rst_j", nmi_j, 1'b0);
        chk("rst_k", nmi_k, 1'b0);
        chk("rst_en", nmi_en, 1'b0);
        chk("rst_wrst", wdog_rst, 1'b0);

        // periodic NMI, ack mid-period, ack coinciding with the terminal tick
        phase = "nmi";
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            cyc = c;
            run_cycle(1'b1, 1'b1, (c == 27) || (c == 36),
                      (c % 4) == 0,
                      (c == 13) || (c == 25) || (c == 37),
                      (c == 28),
                      1'b0);
        end

        // clk_en at half rate; ack lands in a clk_en-low cycle and waits
        phase = "half";
        do_reset();
        for (int c = 1; c <= 26; c++) begin
            cyc = c;
            run_cycle((c % 2) == 1, 1'b1, (c == 10),
                      (c % 8) == 7,
                      (c == 24),
                      (c == 12),
                      1'b0);
        end

        // watchdog expiry twice, ack during FIRE is dropped
        phase = "wdog";
        do_reset();
        for (int c = 1; c <= 55; c++) begin
            cyc = c;
            run_cycle(1'b1, 1'b0, (c == 22),
                      (c <= 20 && (c % 4) == 0) || (c >= 30 && c <= 46 && (c % 4) == 2),
                      (c == 13) || (c == 39),
                      1'b0,
                      (c >= 21 && c <= 26) || (c >= 47 && c <= 52));
        end

        // clearing every third tick keeps the watchdog quiet
        phase = "kick";
        do_reset();
        for (int c = 1; c <= 80; c++) begin
            cyc = c;
            run_cycle(1'b1, (c % 12) == 0, 1'b0,
                      (c % 4) == 0,
                      (c % 12) == 1 && c > 1,
                      1'b0,
                      1'b0);
        end

        // reset applied in the middle of FIRE
        phase = "midrst";
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            cyc = c;
            run_cycle(1'b1, 1'b0, 1'b0,
                      (c <= 20 && (c % 4) == 0),
                      (c == 13),
                      1'b0,
                      (c >= 21));
        end
        cyc = 23;
        rst = 1'b0;
        #1;
        chk("tick_in_rst", tick_3k, 1'b0);
        chk("wrst_before_edge", wdog_rst, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        phase = "after_rst";
        for (int c = 1; c <= 22; c++) begin
            cyc = c;
            run_cycle(1'b1, 1'b0, 1'b0,
                      (c <= 20 && (c % 4) == 0),
                      (c == 13),
                      1'b0,
                      (c >= 21));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
